// File: rtl/alu_ctrl_seq.sv
`default_nettype none
// alu_ctrl_seq: Moore microsequencer issuing fetch/execute/write-back strobes to the model-computer ALU.
// Optional feature macro ALU_SEQ_OPCNT_EN adds OPCNT, a wrapping count of completed (DONE) instructions.
module alu_ctrl_seq (
  input  logic       CLK,
  input  logic       CLRn,
  input  logic [7:0] IR,
  input  logic       IR_VALID,
  output logic       READY,
  output logic       DONE,
  output logic       ILLEGAL,
  output logic       EINn,
  output logic       LDAn,
  output logic       LDBn,
  output logic       ISUM,
  output logic       ISUB,
  output logic       IAND,
  output logic       IOR,
  output logic       ISHL,
  output logic       IXOR,
  output logic       EALU
`ifdef ALU_SEQ_OPCNT_EN
  ,
  output logic [7:0] OPCNT
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DEC  = 3'd1,
    S_FA   = 3'd2,
    S_FB   = 3'd3,
    S_EX   = 3'd4,
    S_WB   = 3'd5,
    S_MV   = 3'd6
  } state_t;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_SHL = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_MOV = 4'h6;
  localparam logic [3:0] OP_NOP = 4'hF;

  // op_n bit order: {ISUM, ISUB, IAND, IOR, ISHL, IXOR}
  typedef struct packed {
    logic       ready;
    logic       done;
    logic       ein_n;
    logic       lda_n;
    logic       ldb_n;
    logic       ealu_n;
    logic [5:0] op_n;
  } outs_t;

  localparam outs_t IDLE_OUTS = '{
    ready:  1'b1,
    done:   1'b0,
    ein_n:  1'b1,
    lda_n:  1'b1,
    ldb_n:  1'b1,
    ealu_n: 1'b1,
    op_n:   6'h3F
  };

  state_t     state_q, state_d;
  logic [3:0] opr_q, opr_d;
  logic       ill_q, ill_d;
  outs_t      out_q, out_d;

  logic unused_ir_low;
  assign unused_ir_low = ^IR[3:0];

  function automatic outs_t decode(input state_t s, input logic [3:0] op);
    outs_t o;
    o       = IDLE_OUTS;
    o.ready = (s == S_IDLE);
    case (s)
      S_FA: begin
        o.ein_n = 1'b0;
        o.lda_n = 1'b0;
      end
      S_FB: begin
        o.ein_n = 1'b0;
        o.ldb_n = 1'b0;
      end
      S_EX: begin
        case (op)
          OP_ADD:  o.op_n[5] = 1'b0;
          OP_SUB:  o.op_n[4] = 1'b0;
          OP_AND:  o.op_n[3] = 1'b0;
          OP_OR:   o.op_n[2] = 1'b0;
          OP_SHL:  o.op_n[1] = 1'b0;
          OP_XOR:  o.op_n[0] = 1'b0;
          default: o.op_n    = 6'h3F;
        endcase
      end
      // Write-back keeps EINn high so the ALU owns the bus alone.
      S_WB: begin
        o.ealu_n = 1'b0;
        o.lda_n  = 1'b0;
        o.done   = 1'b1;
      end
      S_MV: begin
        o.ein_n = 1'b0;
        o.lda_n = 1'b0;
        o.done  = 1'b1;
      end
      default: o.ready = (s == S_IDLE);
    endcase
    return o;
  endfunction

  always_comb begin
    state_d = state_q;
    opr_d   = opr_q;
    ill_d   = ill_q;
    case (state_q)
      S_IDLE: begin
        if (IR_VALID) begin
          opr_d   = IR[7:4];
          ill_d   = 1'b0;
          state_d = S_DEC;
        end
      end
      S_DEC: begin
        if (opr_q <= OP_XOR) begin
          state_d = S_FA;
        end else if (opr_q == OP_MOV) begin
          state_d = S_MV;
        end else if (opr_q == OP_NOP) begin
          state_d = S_IDLE;
        end else begin
          ill_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_FA:    state_d = (opr_q == OP_SHL) ? S_EX : S_FB;
      S_FB:    state_d = S_EX;
      S_EX:    state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      S_MV:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered from the next state so they hold steady across each state cycle.
    out_d = decode(state_d, opr_d);
  end

  always_ff @(posedge CLK or negedge CLRn) begin
    if (!CLRn) begin
      state_q <= S_IDLE;
      opr_q   <= OP_NOP;
      ill_q   <= 1'b0;
      out_q   <= IDLE_OUTS;
    end else begin
      state_q <= state_d;
      opr_q   <= opr_d;
      ill_q   <= ill_d;
      out_q   <= out_d;
    end
  end

  assign READY   = out_q.ready;
  assign DONE    = out_q.done;
  assign ILLEGAL = ill_q;
  assign EINn    = out_q.ein_n;
  assign LDAn    = out_q.lda_n;
  assign LDBn    = out_q.ldb_n;
  assign EALU    = out_q.ealu_n;
  assign ISUM    = out_q.op_n[5];
  assign ISUB    = out_q.op_n[4];
  assign IAND    = out_q.op_n[3];
  assign IOR     = out_q.op_n[2];
  assign ISHL    = out_q.op_n[1];
  assign IXOR    = out_q.op_n[0];

`ifdef ALU_SEQ_OPCNT_EN
  logic [7:0] opcnt_q;

  always_ff @(posedge CLK or negedge CLRn) begin
    if (!CLRn) begin
      opcnt_q <= 8'h00;
    end else if (out_q.done) begin
      opcnt_q <= opcnt_q + 8'h01;
    end
  end

  assign OPCNT = opcnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Microsequencer directly upstream of the model-computer ALU.
- Accepts one 8-bit instruction per handshake and steps the datapath through operand fetch, ALU execute, and result write-back.
- Drives the ALU's active-low operation strobes and output enable, plus accumulator/operand load strobes and the input-bus enable.
- One instruction in flight at a time; Moore machine.

Parameters:
- None. Opcode map and state sequence are fixed.

Ports:
- CLK  in  1  system clock, rising edge
- CLRn  in  1  asynchronous active-low reset
- IR  in  8  instruction; IR[7:4] opcode, IR[3:0] reserved/ignored
- IR_VALID  in  1  instruction present on IR
- READY  out  1  high in IDLE; instruction accepted on edge where IR_VALID&READY
- DONE  out  1  one-cycle high pulse in WB or MOV state
- ILLEGAL  out  1  sticky; set on unknown opcode; cleared by next accepted instruction or reset
- EINn  out  1  active-low: external input drives data bus
- LDAn  out  1  active-low: accumulator (ALU DinA source) loads from bus
- LDBn  out  1  active-low: operand register (ALU Din source) loads from bus
- ISUM, ISUB, IAND, IOR, ISHL, IXOR  out  1 each  active-low ALU op strobes; at most one low in any cycle
- EALU  out  1  active-low ALU result bus enable

Behaviour:
- Reset: CLRn low asynchronously forces IDLE. All active-low outputs go high; READY=1, DONE=0, ILLEGAL=0. Reset mid-instruction aborts with no further strobes.
- All outputs are decoded from the registered state (plus the opcode register), so they are stable for the whole state cycle.
- Opcode register OPR[3:0] loads IR[7:4] on acceptance and holds until the next acceptance.
- Opcodes:
  - 0 ADD→ISUM, 1 SUB→ISUB, 2 AND→IAND, 3 OR→IOR, 4 SHL→ISHL, 5 XOR→IXOR
  - 6 MOV (bus to accumulator)
  - F NOP
  - 7–E illegal
- States and outputs:
  - IDLE: READY=1. On IR_VALID, go to DEC.
  - DEC: no strobes.
    - ALU op → FA.
    - MOV → MV.
    - NOP → IDLE.
    - Illegal → set ILLEGAL, go to IDLE.
  - FA: EINn=0, LDAn=0. Go to FB, except SHL goes to EX (no B operand).
  - FB: EINn=0, LDBn=0. Go to EX.
  - EX: the op's strobe is 0. The ALU result register captures at the end of this cycle. Go to WB.
  - WB: EALU=0, LDAn=0, DONE=1. EINn stays high (no bus contention). Go to IDLE.
  - MV: EINn=0, LDAn=0, DONE=1. Go to IDLE.
- Latency from accept edge (cycle 0) until READY returns:
  - 2-operand ALU op: 5 cycles
  - SHL: 4 cycles
  - MOV: 2 cycles
  - NOP / illegal: 1 cycle
- IR_VALID while READY=0 is ignored. IR changes outside IDLE have no effect.
- IR_VALID held high continuously yields back-to-back instructions, with one IDLE cycle between them.
- Invariants (bench must check every cycle):
  - EINn and EALU are never both low.
  - At most one ALU strobe is low.
  - No strobe is low in IDLE or DEC.

Optional Feature:
- Macro ALU_SEQ_OPCNT_EN.
- When defined:
  - Adds output OPCNT[7:0], reset to 0.
  - Increments on each DONE pulse; wraps FF→00.
  - NOP and illegal opcodes do not count.
- When undefined: no OPCNT port and no counter logic. All other behaviour is identical.

Test Plan:
- Reset check: hold CLRn=0 for 3 cycles → READY=1, DONE=0, ILLEGAL=0, all active-low outputs=1. Release, then IR=0x00 with IR_VALID → FA, FB, EX (ISUM=0), WB (EALU=0, LDAn=0, DONE=1); READY back 5 cycles after accept.
- SHL: IR=0x40 → LDBn never low; ISHL low exactly 1 cycle; DONE 3 cycles after accept; READY at cycle 4.
- MOV and NOP: IR=0x60 → one cycle EINn=LDAn=0 with DONE=1. IR=0xF0 → READY low for exactly 1 cycle, no strobes, DONE=0.
- Illegal: IR=0x90 → ILLEGAL=1 and stays 1 through idle cycles. Next IR=0x20 clears it at acceptance; IAND pulses.
- Abort: pulse CLRn low during EX of SUB → ISUB returns high immediately (asynchronous), no WB/DONE, READY=1. A subsequent XOR runs normally.
- ALU_SEQ_OPCNT_EN defined: issue 257 ADDs plus 2 NOPs and 1 illegal → OPCNT=0x01 (wrap), with invariants asserted throughout.
